// File: rtl/fft_bfp_pkg.sv
// Shared types and constants for the block-floating-point FFT scale controller.
package fft_bfp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned SM_COND   = 0;
  localparam int unsigned SM_UNCOND = 1;
  localparam int unsigned SM_NONE   = 2;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fft_bfp_risk_det.sv
// Flags a complex {im,re} word whose guard bits do not all match its sign bit.
module fft_bfp_risk_det #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned GUARD = 2
) (
  input  logic [2*WIDTH-1:0] word,
  output logic               risky
);

  logic [WIDTH-1:0] re;
  logic [WIDTH-1:0] im;
  logic             re_risky;
  logic             im_risky;

  assign re = word[WIDTH-1:0];
  assign im = word[2*WIDTH-1:WIDTH];

  assign re_risky = (re[WIDTH-2 -: GUARD] != {GUARD{re[WIDTH-1]}});
  assign im_risky = (im[WIDTH-2 -: GUARD] != {GUARD{im[WIDTH-1]}});
  assign risky    = re_risky | im_risky;

  // Bits below the guard band carry no overflow information.
  logic unused_low;
  assign unused_low = ^{re[WIDTH-2-GUARD:0], im[WIDTH-2-GUARD:0]};

endmodule

// File: rtl/fft_bfp_scale_ctrl.sv
// Block-floating-point scaling controller: per-channel load risk, per-stage UPSCALE, frame exponent.
// Optional risky-beat counter output RISK_CNT enabled by defining FFT_BFP_RISK_STATS_EN.
module fft_bfp_scale_ctrl
  import fft_bfp_pkg::*;
#(
  parameter  int unsigned WIDTH      = 18,
  parameter  int unsigned LOGPTS     = 8,
  parameter  int unsigned GUARD      = 2,
  parameter  int unsigned NCH        = 2,
  parameter  int unsigned SCALE_MODE = SM_COND,
  localparam int unsigned CHW        = (clog2(NCH) > 1) ? clog2(NCH) : 1,
  localparam int unsigned EXPW       = clog2(LOGPTS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD_START,
  input  logic [CHW-1:0]       LD_CH,
  input  logic                 LD_VALID,
  input  logic [WIDTH-1:0]     LD_RE,
  input  logic [WIDTH-1:0]     LD_IM,
  input  logic                 FFT_START,
  input  logic [CHW-1:0]       FFT_CH,
  input  logic                 BF_VALID,
  input  logic [2*WIDTH-1:0]   BF_P,
  input  logic [2*WIDTH-1:0]   BF_Q,
  input  logic                 STAGE_END,
  output logic                 UPSCALE,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output logic [EXPW-1:0]      SCALE_EXP,
`ifdef FFT_BFP_RISK_STATS_EN
  output logic [LOGPTS:0]      RISK_CNT,
`endif
  output logic [CHW-1:0]       EXP_CH
);

  localparam int unsigned     NSLOT      = 1 << CHW;
  localparam logic [EXPW-1:0] LAST_STAGE = EXPW'(LOGPTS - 1);
  localparam logic            COND       = (SCALE_MODE == SM_COND);
  localparam logic            UP_FIXED   = (SCALE_MODE == SM_UNCOND);

  state_t           state;
  logic [CHW-1:0]   cur_ch;
  logic [EXPW-1:0]  stage;
  logic [EXPW-1:0]  exp_acc;
  logic             bf_risk;
  logic [NSLOT-1:0] ld_risk;

  logic ld_risky;
  logic p_risky;
  logic q_risky;
  logic beat_risky;

  fft_bfp_risk_det #(.WIDTH(WIDTH), .GUARD(GUARD)) u_det_ld (
    .word  ({LD_IM, LD_RE}),
    .risky (ld_risky)
  );

  fft_bfp_risk_det #(.WIDTH(WIDTH), .GUARD(GUARD)) u_det_p (
    .word  (BF_P),
    .risky (p_risky)
  );

  fft_bfp_risk_det #(.WIDTH(WIDTH), .GUARD(GUARD)) u_det_q (
    .word  (BF_Q),
    .risky (q_risky)
  );

  assign beat_risky = BF_VALID & (p_risky | q_risky);

  // Load-side risk flags run independently of the frame FSM so ping-pong loads overlap a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ld_risk <= '0;
    end else if (LD_START) begin
      ld_risk[LD_CH] <= 1'b0;
    end else if (LD_VALID && ld_risky) begin
      ld_risk[LD_CH] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cur_ch     <= '0;
      stage      <= '0;
      exp_acc    <= '0;
      bf_risk    <= 1'b0;
      UPSCALE    <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      SCALE_EXP  <= '0;
      EXP_CH     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (FFT_START) begin
            state   <= S_RUN;
            BUSY    <= 1'b1;
            cur_ch  <= FFT_CH;
            stage   <= '0;
            exp_acc <= '0;
            bf_risk <= 1'b0;
            UPSCALE <= COND ? ld_risk[FFT_CH] : UP_FIXED;
          end
        end
        S_RUN: begin
          if (STAGE_END) begin
            // A beat coincident with STAGE_END still belongs to the ending stage.
            exp_acc <= exp_acc + EXPW'(UPSCALE);
            stage   <= stage + EXPW'(1);
            UPSCALE <= COND ? (bf_risk | beat_risky) : UP_FIXED;
            bf_risk <= 1'b0;
            if (stage == LAST_STAGE) begin
              state      <= S_DONE;
              FRAME_DONE <= 1'b1;
              SCALE_EXP  <= exp_acc + EXPW'(UPSCALE);
              EXP_CH     <= cur_ch;
            end
          end else if (beat_risky) begin
            bf_risk <= 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          BUSY       <= 1'b0;
          FRAME_DONE <= 1'b0;
          UPSCALE    <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFT_BFP_RISK_STATS_EN
  localparam int unsigned RCW = LOGPTS + 1;

  logic [RCW-1:0] risk_acc;
  logic [RCW-1:0] risk_next;

  assign risk_next = (beat_risky && (risk_acc != '1)) ? risk_acc + RCW'(1) : risk_acc;

  // Saturating risky-beat count, published together with SCALE_EXP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      risk_acc <= '0;
      RISK_CNT <= '0;
    end else begin
      if (state == S_IDLE && FFT_START) begin
        risk_acc <= '0;
      end else if (state == S_RUN) begin
        risk_acc <= risk_next;
      end
      if (state == S_RUN && STAGE_END && stage == LAST_STAGE) begin
        RISK_CNT <= risk_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_bfp_scale_ctrl.sv
// Self-checking bench for fft_bfp_scale_ctrl: vector table for conditional mode, plus reset and fixed-mode sequences.
module tb_fft_bfp_scale_ctrl;

  localparam int unsigned W   = 18;
  localparam int unsigned LP  = 3;
  localparam int unsigned LPU = 8;

  localparam logic [2*W-1:0] SAFE_P  = {18'h38001, 18'h07FFF};
  localparam logic [2*W-1:0] SAFE_Q  = {18'h00000, 18'h3FFFF};
  localparam logic [2*W-1:0] RISKY_P = {18'h00001, 18'h10000};
  localparam logic [2*W-1:0] RISKY_Q = {18'h20000, 18'h00000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           ld_start;
  logic           ld_ch;
  logic           ld_valid;
  logic [W-1:0]   ld_re;
  logic [W-1:0]   ld_im;
  logic           fft_start;
  logic           fft_ch;
  logic           bf_valid;
  logic [2*W-1:0] bf_p;
  logic [2*W-1:0] bf_q;
  logic           stage_end;
  logic           fft_start2;
  logic           stage_end2;

  logic       upscale, busy, frame_done, exp_ch;
  logic [1:0] scale_exp;
  logic       upscale_u, busy_u, frame_done_u, exp_ch_u;
  logic [3:0] scale_exp_u;
  logic       upscale_n, busy_n, frame_done_n, exp_ch_n;
  logic [3:0] scale_exp_n;
`ifdef FFT_BFP_RISK_STATS_EN
  logic [LP:0]  risk_cnt;
  logic [LPU:0] risk_cnt_u;
  logic [LPU:0] risk_cnt_n;
`endif

  fft_bfp_scale_ctrl #(.WIDTH(W), .LOGPTS(LP), .GUARD(2), .NCH(2), .SCALE_MODE(0)) dut (
    .CLK(clk), .RST(rst), .LD_START(ld_start), .LD_CH(ld_ch), .LD_VALID(ld_valid),
    .LD_RE(ld_re), .LD_IM(ld_im), .FFT_START(fft_start), .FFT_CH(fft_ch),
    .BF_VALID(bf_valid), .BF_P(bf_p), .BF_Q(bf_q), .STAGE_END(stage_end),
    .UPSCALE(upscale), .BUSY(busy), .FRAME_DONE(frame_done), .SCALE_EXP(scale_exp),
`ifdef FFT_BFP_RISK_STATS_EN
    .RISK_CNT(risk_cnt),
`endif
    .EXP_CH(exp_ch)
  );

  fft_bfp_scale_ctrl #(.WIDTH(W), .LOGPTS(LPU), .GUARD(2), .NCH(2), .SCALE_MODE(1)) dut_u (
    .CLK(clk), .RST(rst), .LD_START(ld_start), .LD_CH(ld_ch), .LD_VALID(ld_valid),
    .LD_RE(ld_re), .LD_IM(ld_im), .FFT_START(fft_start2), .FFT_CH(1'b0),
    .BF_VALID(bf_valid), .BF_P(bf_p), .BF_Q(bf_q), .STAGE_END(stage_end2),
    .UPSCALE(upscale_u), .BUSY(busy_u), .FRAME_DONE(frame_done_u), .SCALE_EXP(scale_exp_u),
`ifdef FFT_BFP_RISK_STATS_EN
    .RISK_CNT(risk_cnt_u),
`endif
    .EXP_CH(exp_ch_u)
  );

  fft_bfp_scale_ctrl #(.WIDTH(W), .LOGPTS(LPU), .GUARD(2), .NCH(2), .SCALE_MODE(2)) dut_n (
    .CLK(clk), .RST(rst), .LD_START(ld_start), .LD_CH(ld_ch), .LD_VALID(ld_valid),
    .LD_RE(ld_re), .LD_IM(ld_im), .FFT_START(fft_start2), .FFT_CH(1'b1),
    .BF_VALID(bf_valid), .BF_P(bf_p), .BF_Q(bf_q), .STAGE_END(stage_end2),
    .UPSCALE(upscale_n), .BUSY(busy_n), .FRAME_DONE(frame_done_n), .SCALE_EXP(scale_exp_n),
`ifdef FFT_BFP_RISK_STATS_EN
    .RISK_CNT(risk_cnt_n),
`endif
    .EXP_CH(exp_ch_n)
  );

  // Frame vector: inputs to apply and the expected per-stage UPSCALE and frame exponent.
  typedef struct {
    logic       ch;
    logic       load;
    logic       ld_risky;
    logic [2:0] mask;
    int         rpb;
    logic       coincide;
    logic       ld_during;
    logic       start_mid;
    logic [2:0] ups;
    int         exp_val;
  } vec_t;

  typedef struct {
    logic       ch;
    logic [1:0] sexp;
    int         rcnt;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ch(input logic ch, input logic risky);
    // A risky sample on the LD_START cycle must be overridden by the clear.
    ld_start = 1'b1; ld_ch = ch; ld_valid = 1'b1; ld_re = 18'h10000; ld_im = '0;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_re    = (risky && i == 2) ? 18'h10000 : 18'h07FFF - W'(i);
      ld_im    = 18'h38001;
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    exp_t e;
    if (v.load) load_ch(v.ch, v.ld_risky);
    e.ch   = v.ch;
    e.sexp = 2'(v.exp_val);
    e.rcnt = $countones(v.mask) * v.rpb + int'(v.coincide);
    sbq.push_back(e);
    fft_ch = v.ch; fft_start = 1'b1;
    tick();
    fft_start = 1'b0;
    check({tag, "_ups_s0"}, upscale, v.ups[0]);
    check({tag, "_busy"}, busy, 1);
    for (int s = 0; s < int'(LP); s++) begin
      for (int b = 0; b < 3; b++) begin
        bf_valid = 1'b1; bf_p = SAFE_P; bf_q = SAFE_Q;
        if (v.mask[s] && b < v.rpb) begin
          if (b == 0) bf_p = RISKY_P;
          else bf_q = RISKY_Q;
        end
        if (v.ld_during && s == 0) begin
          ld_ch = 1'b1; ld_valid = 1'b1; ld_im = '0;
          ld_start = (b == 0);
          ld_re    = (b == 1) ? 18'h10000 : 18'h00100;
        end
        if (v.start_mid && s == 1 && b == 0) begin
          fft_start = 1'b1; fft_ch = ~v.ch;
        end
        tick();
        fft_start = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
      end
      bf_valid = 1'b1; bf_p = SAFE_P;
      bf_q = (v.coincide && s == 0) ? RISKY_Q : SAFE_Q;
      stage_end = 1'b1;
      tick();
      stage_end = 1'b0; bf_valid = 1'b0;
      if (s < int'(LP) - 1) check($sformatf("%s_ups_s%0d", tag, s + 1), upscale, v.ups[s+1]);
      else check({tag, "_frame_done"}, frame_done, 1);
    end
    tick();
    check({tag, "_done_clear"}, {busy, frame_done, upscale}, 3'b000);
  endtask

  // Scoreboard: each FRAME_DONE must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        check("scale_exp", scale_exp, mon_e.sexp);
        check("exp_ch", exp_ch, mon_e.ch);
`ifdef FFT_BFP_RISK_STATS_EN
        check("risk_cnt", risk_cnt, mon_e.rcnt);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: ch, load, ld_risky, mask, rpb, coincide, ld_during, start_mid, ups, exp_val
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1, 1'b0, 1'b0, 1'b0, 3'b000, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 3'b010, 1, 1'b0, 1'b0, 1'b0, 3'b101, 2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b011, 2, 1'b1, 1'b0, 1'b0, 3'b110, 2};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 3'b111, 1, 1'b0, 1'b0, 1'b0, 3'b111, 3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b100, 1, 1'b0, 1'b0, 1'b0, 3'b000, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1, 1'b1, 1'b0, 1'b1, 3'b010, 1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1, 1'b0, 1'b0, 1'b0, 3'b000, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1, 1'b0, 1'b1, 1'b0, 3'b000, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 1'b0, 1'b0, 1'b0, 3'b001, 1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 1'b0, 1'b0, 1'b0, 3'b000, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b000, 1, 1'b0, 1'b0, 1'b0, 3'b000, 0};

    rst = 1'b1; ld_start = 1'b0; ld_ch = 1'b0; ld_valid = 1'b0; ld_re = '0; ld_im = '0;
    fft_start = 1'b0; fft_ch = 1'b0; bf_valid = 1'b0; bf_p = '0; bf_q = '0;
    stage_end = 1'b0; fft_start2 = 1'b0; stage_end2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outputs", {upscale, busy, frame_done, scale_exp, exp_ch}, 5'b0);
    check("reset_outputs_u", {upscale_u, busy_u, frame_done_u, scale_exp_u, exp_ch_u}, 8'b0);

    for (int i = 0; i < 9; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Abort a frame at stage 2 with reset; load flags must also clear.
    load_ch(1'b1, 1'b1);
    load_ch(1'b0, 1'b1);
    fft_ch = 1'b1; fft_start = 1'b1;
    tick();
    fft_start = 1'b0;
    check("rst_seq_ups_s0", upscale, 1);
    for (int s = 0; s < 2; s++) begin
      bf_valid = 1'b1; bf_p = SAFE_P; bf_q = SAFE_Q; stage_end = 1'b1;
      tick();
      stage_end = 1'b0; bf_valid = 1'b0;
      check($sformatf("rst_seq_ups_s%0d", s + 1), upscale, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_abort", {busy, upscale, frame_done}, 3'b000);
    tick();
    check("rst_no_done", frame_done, 0);
    stage_end = 1'b1;
    tick();
    stage_end = 1'b0;
    check("idle_stage_end", {busy, upscale}, 2'b00);

    for (int i = 9; i < 11; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Fixed policies over 8 stages with every beat risky.
    fft_start2 = 1'b1;
    tick();
    fft_start2 = 1'b0;
    check("uncond_ups_s0", upscale_u, 1);
    check("none_ups_s0", upscale_n, 0);
    check("uncond_busy", busy_u, 1);
    for (int s = 0; s < int'(LPU); s++) begin
      bf_valid = 1'b1; bf_p = RISKY_P; bf_q = RISKY_Q; stage_end2 = 1'b1;
      tick();
      stage_end2 = 1'b0; bf_valid = 1'b0;
      if (s < int'(LPU) - 1) begin
        check($sformatf("uncond_ups_s%0d", s + 1), upscale_u, 1);
        check($sformatf("none_ups_s%0d", s + 1), upscale_n, 0);
      end else begin
        check("uncond_done", frame_done_u, 1);
        check("none_done", frame_done_n, 1);
        check("uncond_exp", scale_exp_u, 8);
        check("none_exp", scale_exp_n, 0);
        check("none_exp_ch", exp_ch_n, 1);
`ifdef FFT_BFP_RISK_STATS_EN
        check("uncond_risk_cnt", risk_cnt_u, 8);
`endif
      end
    end
    tick();
    check("uncond_idle", {busy_u, busy_n, upscale_u}, 3'b000);
    check("main_idle", busy, 0);

    tick();
    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
